// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register (hold / shift right / shift left / load) with a saturating shift counter.
// Optional macro USR_ROTATE_EN adds a rot input that turns both shift modes into rotates.
module universal_shift_register #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
`ifdef USR_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    cnt,
    output logic             flushed
);

    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    logic rot_en;
    logic fill_r;
    logic fill_l;

    // In rotate mode the bit leaving one end wraps around to the other.
    always_comb begin
`ifdef USR_ROTATE_EN
        rot_en = rot;
`else
        rot_en = 1'b0;
`endif
        fill_r = rot_en ? Q[0]       : sin_r;
        fill_l = rot_en ? Q[WIDTH-1] : sin_l;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            Q   <= '0;
            cnt <= '0;
        end else begin
            case (mode)
                2'b00: begin
                    Q   <= Q;
                    cnt <= cnt;
                end
                2'b01: begin
                    Q   <= {fill_r, Q[WIDTH-1:1]};
                    cnt <= (cnt == FULL) ? cnt : cnt + 1'b1;
                end
                2'b10: begin
                    Q   <= {Q[WIDTH-2:0], fill_l};
                    cnt <= (cnt == FULL) ? cnt : cnt + 1'b1;
                end
                2'b11: begin
                    Q   <= D;
                    cnt <= '0;
                end
                default: begin
                    Q   <= 'x;
                    cnt <= 'x;
                end
            endcase
        end
    end

    assign sout_r  = Q[0];
    assign sout_l  = Q[WIDTH-1];
    assign flushed = (cnt == FULL);

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH = 4), directed scenarios plus randomized traffic.
// Rotate scenarios are compiled in when USR_ROTATE_EN is defined.
module tb_universal_shift_register;

    localparam int WIDTH = 4;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic             sin_r = 1'b0;
    logic             sin_l = 1'b0;
    logic             rot = 1'b0;
    logic [WIDTH-1:0] D = '0;
    logic [WIDTH-1:0] Q;
    logic             sout_r;
    logic             sout_l;
    logic [CW-1:0]    cnt;
    logic             flushed;

    int m_q;
    int m_cnt;
    int n_checks = 0;
    int n_fail   = 0;

    universal_shift_register #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .nrst(nrst),
        .mode(mode),
        .sin_r(sin_r),
        .sin_l(sin_l),
`ifdef USR_ROTATE_EN
        .rot(rot),
`endif
        .D(D),
        .Q(Q),
        .sout_r(sout_r),
        .sout_l(sout_l),
        .cnt(cnt),
        .flushed(flushed)
    );

    always #10 clk = ~clk;

    // Drive one clock edge and advance the reference model; outputs are then sampled 1 time unit after the edge.
    task automatic drive_edge(input logic [1:0] md, input int d, input logic sr, input logic sl, input logic rt);
        mode  = md;
        D     = d[WIDTH-1:0];
        sin_r = sr;
        sin_l = sl;
        rot   = rt;
        @(posedge clk);
        #1;
        case (md)
            2'b01: begin
                m_q   = (m_q / 2) + 8 * (rt ? (m_q % 2) : int'(sr));
                m_cnt = (m_cnt < WIDTH) ? m_cnt + 1 : WIDTH;
            end
            2'b10: begin
                m_q   = ((m_q * 2) % 16) + (rt ? (m_q / 8) : int'(sl));
                m_cnt = (m_cnt < WIDTH) ? m_cnt + 1 : WIDTH;
            end
            2'b11: begin
                m_q   = d % 16;
                m_cnt = 0;
            end
            default: ;
        endcase
    endtask

    task automatic test_reset();
        n_checks++;
        if (Q !== 4'b0000 || cnt !== 3'd0 || flushed !== 1'b0 || sout_r !== 1'b0 || sout_l !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: Q=%b cnt=%0d flushed=%b sout_r=%b sout_l=%b, required Q=0000 cnt=0 flushed=0 souts=0",
                     Q, cnt, flushed, sout_r, sout_l);
        end
    endtask

    task automatic test_load();
        drive_edge(2'b11, 4'b1011, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_edge(2'b00, 4'b0110, 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (Q !== 4'b1011 || cnt !== 3'd0 || flushed !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL load_hold[%0d]: Q=%b cnt=%0d flushed=%b, required Q=1011 cnt=0 flushed=0",
                         i, Q, cnt, flushed);
            end
        end
    endtask

    task automatic test_shift_right();
        logic [3:0] exp_q [4] = '{4'b0101, 4'b0010, 4'b0001, 4'b0000};
        logic       exp_s [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        drive_edge(2'b11, 4'b1011, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (sout_r !== exp_s[i]) begin
                n_fail++;
                $display("[TB] FAIL shr_sout_r[%0d]: got %b, required %b", i, sout_r, exp_s[i]);
            end
            drive_edge(2'b01, 4'b1111, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (Q !== exp_q[i] || cnt !== CW'(i + 1) || flushed !== (i == 3)) begin
                n_fail++;
                $display("[TB] FAIL shr_step[%0d]: Q=%b cnt=%0d flushed=%b, required Q=%b cnt=%0d flushed=%0d",
                         i, Q, cnt, flushed, exp_q[i], i + 1, (i == 3));
            end
        end
    endtask

    task automatic test_shift_left();
        logic [3:0] exp_q [6] = '{4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
        drive_edge(2'b11, 4'b0001, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive_edge(2'b10, 4'b0000, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (Q !== exp_q[i] || cnt !== CW'((i < 3) ? i + 1 : 4) || flushed !== (i >= 3)) begin
                n_fail++;
                $display("[TB] FAIL shl_step[%0d]: Q=%b cnt=%0d flushed=%b, required Q=%b cnt=%0d flushed=%0d",
                         i, Q, cnt, flushed, exp_q[i], (i < 3) ? i + 1 : 4, (i >= 3));
            end
            n_checks++;
            if (sout_l !== exp_q[i][3]) begin
                n_fail++;
                $display("[TB] FAIL shl_sout_l[%0d]: got %b, required %b", i, sout_l, exp_q[i][3]);
            end
        end
        drive_edge(2'b11, 4'b0000, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (Q !== 4'b0000 || cnt !== 3'd0 || flushed !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL shl_reload: Q=%b cnt=%0d flushed=%b, required Q=0000 cnt=0 flushed=0", Q, cnt, flushed);
        end
    endtask

    task automatic test_async_reset();
        drive_edge(2'b11, 4'b1111, 1'b0, 1'b0, 1'b0);
        drive_edge(2'b01, 4'b0000, 1'b1, 1'b0, 1'b0);
        drive_edge(2'b01, 4'b0000, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (Q !== 4'b1111 || cnt !== 3'd2) begin
            n_fail++;
            $display("[TB] FAIL areset_pre: Q=%b cnt=%0d, required Q=1111 cnt=2", Q, cnt);
        end
        mode = 2'b00;
        #4 nrst = 1'b0;
        #2;
        n_checks++;
        if (Q !== 4'b0000 || cnt !== 3'd0 || flushed !== 1'b0 || sout_l !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL areset_immediate: Q=%b cnt=%0d flushed=%b, required Q=0000 cnt=0 flushed=0", Q, cnt, flushed);
        end
        #3 nrst = 1'b1;
        m_q   = 0;
        m_cnt = 0;
        drive_edge(2'b00, 4'b1111, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (Q !== 4'b0000 || cnt !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL areset_hold: Q=%b cnt=%0d, required Q=0000 cnt=0", Q, cnt);
        end
    endtask

    task automatic test_mixed();
        drive_edge(2'b11, 4'b1000, 1'b0, 1'b0, 1'b0);
        drive_edge(2'b01, 4'b0000, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (Q !== 4'b1100 || cnt !== 3'd1) begin
            n_fail++;
            $display("[TB] FAIL mixed_right: Q=%b cnt=%0d, required Q=1100 cnt=1", Q, cnt);
        end
        drive_edge(2'b10, 4'b0000, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (Q !== 4'b1000 || cnt !== 3'd2) begin
            n_fail++;
            $display("[TB] FAIL mixed_left: Q=%b cnt=%0d, required Q=1000 cnt=2", Q, cnt);
        end
    endtask

`ifdef USR_ROTATE_EN
    task automatic test_rotate();
        logic [3:0] exp_q [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
        drive_edge(2'b11, 4'b1001, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive_edge(2'b01, 4'b0000, 1'b0, 1'b1, 1'b1);
            n_checks++;
            if (Q !== exp_q[i] || cnt !== CW'(i + 1) || flushed !== (i == 3)) begin
                n_fail++;
                $display("[TB] FAIL rotate_step[%0d]: Q=%b cnt=%0d flushed=%b, required Q=%b cnt=%0d flushed=%0d",
                         i, Q, cnt, flushed, exp_q[i], i + 1, (i == 3));
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [1:0] md;
        logic       rt;
        for (int i = 0; i < 300; i++) begin
            md = 2'($urandom_range(0, 3));
            // Keep loads rare so the counter regularly reaches saturation.
            if (md == 2'b11 && $urandom_range(0, 3) != 0) md = 2'b01 + 2'($urandom_range(0, 1));
`ifdef USR_ROTATE_EN
            rt = 1'($urandom_range(0, 1));
`else
            rt = 1'b0;
`endif
            drive_edge(md, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rt);
            n_checks++;
            if (Q !== 4'(m_q) || cnt !== CW'(m_cnt) || flushed !== (m_cnt == WIDTH) ||
                sout_r !== 1'(m_q % 2) || sout_l !== 1'(m_q / 8)) begin
                n_fail++;
                $display("[TB] FAIL random[%0d] mode=%b rot=%b: Q=%b cnt=%0d flushed=%b sout_r=%b sout_l=%b, required Q=%b cnt=%0d",
                         i, md, rt, Q, cnt, flushed, sout_r, sout_l, 4'(m_q), m_cnt);
            end
        end
    endtask

    initial begin
        m_q   = 0;
        m_cnt = 0;
        #15;
        test_reset();
        nrst = 1'b1;
        test_load();
        test_shift_right();
        test_shift_left();
        test_async_reset();
        test_mixed();
`ifdef USR_ROTATE_EN
        test_rotate();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
